id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Parametrised pipeline register that generalises the ID→EX boundary into a reusable stage register for any adjacent stage pair. It captures a DW-bit payload plus a valid bit and delay-slot tags, and applies a priority order: asynchronous reset, flush, bubble, hold, advance. A bubble is inserted when the upstream stage stalls and the downstream stage does not. Optional saturating performance counters record bubble, hold and flush cycles.

## Interface
Parameters:
- DW, 64, payload width in bits (≥1).
- NOP_VAL, {DW{1'b0}}, payload driven on reset, flush, bubble or invalid capture.
- STALL_W, 6, width of the stall vector from the control module.
- STAGE, 2, index of this register's stall bit; the downstream bit is STAGE+1.
- CNT_W, 16, width of each perf counter (only with PIPE_REG_PERF_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  STALL_W  per-stage stall vector; 1 = Stop.
- flush  in  1  synchronous squash (exception/redirect).
- in_data  in  DW  payload from the upstream stage.
- in_valid  in  1  upstream payload valid.
- in_dslot  in  1  upstream instruction is in a delay slot.
- next_dslot_i  in  1  next upstream instruction will be in a delay slot.
- out_data  out  DW  registered payload.
- out_valid  out  1  registered valid.
- out_dslot  out  1  registered delay-slot tag.
- dslot_loop_o  out  1  registered next_dslot_i, looped back to the upstream stage.
- perf_clr  in  1  synchronous clear of all counters (PIPE_REG_PERF_EN only).
- bubble_cnt, hold_cnt, flush_cnt  out  CNT_W  each  event counters (PIPE_REG_PERF_EN only).

## Operation
- Definitions: up_stop = stall[STAGE]. dn_stop = stall[STAGE+1]; when STAGE == STALL_W-1, dn_stop = 0.
- rst low (asynchronous): out_data = NOP_VAL; out_valid, out_dslot and dslot_loop_o = 0; all counters = 0. Every output has a reset value.
- Each rising clk edge with rst high applies the first matching rule:
  1. FLUSH (flush = 1): out_data = NOP_VAL; out_valid, out_dslot and dslot_loop_o = 0. Overrides any stall.
  2. BUBBLE (up_stop & !dn_stop): out_data = NOP_VAL; out_valid and out_dslot = 0; dslot_loop_o holds.
  3. HOLD (up_stop & dn_stop): all outputs hold.
  4. ADVANCE (!up_stop):
     - out_valid = in_valid.
     - out_data = in_valid ? in_data : NOP_VAL.
     - out_dslot = in_valid & in_dslot.
     - dslot_loop_o = next_dslot_i.
- Every output field is written in the FLUSH, BUBBLE and ADVANCE rules. No field is left unassigned in any branch.
- The !up_stop & dn_stop combination is illegal from the control module. It is treated as ADVANCE, with no special handling.
- Stage status, derived from out_valid plus the rule applied: EMPTY (out_valid = 0), FULL (out_valid = 1), HELD (FULL and rule 3 applied this cycle).

## Timing
- Latency is 1 cycle: an input sampled on edge N appears on the outputs after edge N.
- Outputs are driven only by flops; there is no combinational input→output path.
- Flush and stall in the same cycle: flush wins, and the stage is EMPTY on the next cycle.
- Reset deasserting mid-stall: the first edge after release evaluates the rules normally, starting from the reset values.
- A hold of any length keeps the payload bit-exact. The first !up_stop edge then advances.
- Counters update on the same edge as the event they count.

## Configuration
- PIPE_REG_PERF_EN defined:
  - bubble_cnt increments on each BUBBLE edge.
  - hold_cnt increments on each HOLD edge while out_valid = 1.
  - flush_cnt increments on each FLUSH edge.
  - All three saturate at 2^CNT_W−1.
  - perf_clr zeroes all three; when perf_clr and an event occur in the same cycle, the result is 0.
- PIPE_REG_PERF_EN undefined: perf_clr and the counter ports are absent, no counter logic is generated, and stage behaviour is otherwise identical.

## Test plan
- Reset: drive rst = 0 mid-cycle with in_valid = 1 and in_data = 0xDEAD → outputs go to NOP_VAL/0 immediately, without waiting for clk. After release, one ADVANCE edge → out_data = 0xDEAD, out_valid = 1.
- Bubble: stall = 6'b000111 (STAGE = 2) with in_data = 0x1234 → out_valid = 0, out_data = 0, dslot_loop_o unchanged, bubble_cnt +1.
- Hold: load 0xABCD, then hold with stall = 6'b001111 for 5 cycles → out_data stays 0xABCD each cycle and hold_cnt = 5. Release → the next in_data is captured.
- Flush priority: flush = 1 with stall = 6'b001111 and out_valid = 1 → next cycle out_valid = 0, out_dslot = 0, dslot_loop_o = 0, flush_cnt = 1.
- Delay slot: advance with next_dslot_i = 1 → dslot_loop_o = 1. Next advance with in_dslot = 1, in_valid = 1 → out_dslot = 1. Same but in_valid = 0 → out_dslot = 0 and out_data = NOP_VAL.
- Counters (CNT_W = 4): 20 consecutive BUBBLE edges → bubble_cnt = 15 (saturated). perf_clr coincident with a bubble → 0.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// Stage-boundary bus for id_ex_pipe_reg: upstream payload/control in, registered stage outputs back.
// Counter signals exist only when PIPE_REG_PERF_EN is defined.
interface id_ex_pipe_reg_if #(
  parameter int unsigned DW      = 64,
  parameter int unsigned STALL_W = 6
`ifdef PIPE_REG_PERF_EN
  , parameter int unsigned CNT_W = 16
`endif
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [DW-1:0]      in_data;
  logic               in_valid;
  logic               in_dslot;
  logic               next_dslot_i;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic               out_dslot;
  logic               dslot_loop_o;
`ifdef PIPE_REG_PERF_EN
  logic               perf_clr;
  logic [CNT_W-1:0]   bubble_cnt;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   flush_cnt;
`endif

  // master: the upstream/control side that drives the stage
  modport master (
    output stall, flush, in_data, in_valid, in_dslot, next_dslot_i,
`ifdef PIPE_REG_PERF_EN
    output perf_clr,
    input  bubble_cnt, hold_cnt, flush_cnt,
`endif
    input  out_data, out_valid, out_dslot, dslot_loop_o
  );

  // slave: the pipeline register itself
  modport slave (
    input  stall, flush, in_data, in_valid, in_dslot, next_dslot_i,
`ifdef PIPE_REG_PERF_EN
    input  perf_clr,
    output bubble_cnt, hold_cnt, flush_cnt,
`endif
    output out_data, out_valid, out_dslot, dslot_loop_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// Generic pipeline stage register (flush > bubble > hold > advance) with delay-slot tagging.
// Define PIPE_REG_PERF_EN to add saturating bubble/hold/flush counters and perf_clr.
module id_ex_pipe_reg #(
  parameter int unsigned    DW      = 64,
  parameter logic [DW-1:0]  NOP_VAL = '0,
  parameter int unsigned    STALL_W = 6,
  parameter int unsigned    STAGE   = 2
`ifdef PIPE_REG_PERF_EN
  , parameter int unsigned  CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_pipe_reg_if.slave   bus,
  output logic [1:0]        status_o
);

  // Handshake: stall[STAGE]=1 means this stage is not ready, so the upstream payload is
  // only consumed on an ADVANCE edge; stall[STAGE+1]=1 means downstream is not ready and
  // this stage must keep its contents; out_valid qualifies out_data/out_dslot.

  typedef enum logic [1:0] {
    RULE_FLUSH   = 2'd0,
    RULE_BUBBLE  = 2'd1,
    RULE_HOLD    = 2'd2,
    RULE_ADVANCE = 2'd3
  } rule_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HELD  = 2'd2
  } status_e;

  logic          up_stop;
  logic          dn_stop;
  rule_e         rule;

  logic [DW-1:0] data_q,  data_d;
  logic          valid_q, valid_d;
  logic          dslot_q, dslot_d;
  logic          loop_q,  loop_d;
  status_e       status_q, status_d;

  assign up_stop = bus.stall[STAGE];

  // The last stage has no downstream stall bit.
  generate
    if (STAGE + 1 < STALL_W) begin : g_dn_stop
      assign dn_stop = bus.stall[STAGE+1];
    end else begin : g_dn_last
      assign dn_stop = 1'b0;
    end
  endgenerate

  // !up_stop & dn_stop is never produced by the controller and simply advances.
  always_comb begin
    if (bus.flush) begin
      rule = RULE_FLUSH;
    end else if (up_stop && !dn_stop) begin
      rule = RULE_BUBBLE;
    end else if (up_stop) begin
      rule = RULE_HOLD;
    end else begin
      rule = RULE_ADVANCE;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    dslot_d = dslot_q;
    loop_d  = loop_q;
    unique case (rule)
      RULE_FLUSH: begin
        data_d  = NOP_VAL;
        valid_d = 1'b0;
        dslot_d = 1'b0;
        loop_d  = 1'b0;
      end
      RULE_BUBBLE: begin
        data_d  = NOP_VAL;
        valid_d = 1'b0;
        dslot_d = 1'b0;
        loop_d  = loop_q;
      end
      RULE_HOLD: begin
        data_d  = data_q;
        valid_d = valid_q;
        dslot_d = dslot_q;
        loop_d  = loop_q;
      end
      RULE_ADVANCE: begin
        data_d  = bus.in_valid ? bus.in_data : NOP_VAL;
        valid_d = bus.in_valid;
        dslot_d = bus.in_valid & bus.in_dslot;
        loop_d  = bus.next_dslot_i;
      end
      default: begin
        data_d  = NOP_VAL;
        valid_d = 1'b0;
        dslot_d = 1'b0;
        loop_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    if (!valid_d) begin
      status_d = ST_EMPTY;
    end else if (rule == RULE_HOLD) begin
      status_d = ST_HELD;
    end else begin
      status_d = ST_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= NOP_VAL;
      valid_q  <= 1'b0;
      dslot_q  <= 1'b0;
      loop_q   <= 1'b0;
      status_q <= ST_EMPTY;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      dslot_q  <= dslot_d;
      loop_q   <= loop_d;
      status_q <= status_d;
    end
  end

  assign bus.out_data     = data_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_dslot    = dslot_q;
  assign bus.dslot_loop_o = loop_q;
  assign status_o         = status_q;

`ifdef PIPE_REG_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    if (ev && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // Clear wins over a coincident event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
      flush_cnt_q  <= '0;
    end else if (bus.perf_clr) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= sat_inc(bubble_cnt_q, rule == RULE_BUBBLE);
      hold_cnt_q   <= sat_inc(hold_cnt_q, (rule == RULE_HOLD) && valid_q);
      flush_cnt_q  <= sat_inc(flush_cnt_q, rule == RULE_FLUSH);
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.hold_cnt   = hold_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
`endif

  // An empty stage always carries the NOP payload and no delay-slot tag.
  a_empty_is_nop: assert property (@(posedge clk) disable iff (!rst)
    !valid_q |-> ((data_q == NOP_VAL) && !dslot_q));

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, bubble, hold, flush priority, delay slot, last-stage
// bubble and (with PIPE_REG_PERF_EN) counter saturation/clear.
module tb_id_ex_pipe_reg;
  localparam int DW      = 64;
  localparam int STALL_W = 6;
  localparam int STAGE   = 2;
`ifdef PIPE_REG_PERF_EN
  localparam int CNT_W   = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] status;
  logic [1:0] status_l;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  id_ex_pipe_reg_if #(.DW(DW), .STALL_W(STALL_W)
`ifdef PIPE_REG_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();

  id_ex_pipe_reg_if #(.DW(DW), .STALL_W(STALL_W)
`ifdef PIPE_REG_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) bus_l ();

  id_ex_pipe_reg #(.DW(DW), .STALL_W(STALL_W), .STAGE(STAGE)
`ifdef PIPE_REG_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .status_o (status)
  );

  // Last stage in the vector: no downstream stall bit exists.
  id_ex_pipe_reg #(.DW(DW), .STALL_W(STALL_W), .STAGE(STALL_W-1)
`ifdef PIPE_REG_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) u_dut_last (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_l),
    .status_o (status_l)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [STALL_W-1:0] st, input logic fl, input logic [DW-1:0] d,
                       input logic v, input logic ds, input logic nds);
    bus.stall        = st;
    bus.flush        = fl;
    bus.in_data      = d;
    bus.in_valid     = v;
    bus.in_dslot     = ds;
    bus.next_dslot_i = nds;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive('0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    bus_l.stall = '0; bus_l.flush = 1'b0; bus_l.in_data = '0;
    bus_l.in_valid = 1'b0; bus_l.in_dslot = 1'b0; bus_l.next_dslot_i = 1'b0;
`ifdef PIPE_REG_PERF_EN
    bus.perf_clr = 1'b0;
    bus_l.perf_clr = 1'b0;
`endif
    tick();
    tick();
    check("rst_data",   bus.out_data, 64'h0);
    check("rst_valid",  bus.out_valid, 1'b0);
    check("rst_dslot",  bus.out_dslot, 1'b0);
    check("rst_loop",   bus.dslot_loop_o, 1'b0);
    check("rst_status", status, 2'd0);

    // first advance after reset
    rst = 1'b1;
    drive(6'b000000, 1'b0, 64'hDEAD, 1'b1, 1'b0, 1'b0);
    tick();
    check("adv_data",   bus.out_data, 64'hDEAD);
    check("adv_valid",  bus.out_valid, 1'b1);
    check("adv_status", status, 2'd1);

    // async reset mid-cycle, then release while held
    #2 rst = 1'b0;
    #1;
    check("async_rst_data",  bus.out_data, 64'h0);
    check("async_rst_valid", bus.out_valid, 1'b0);
    drive(6'b001111, 1'b0, 64'hDEAD, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    tick();
    check("rel_hold_valid", bus.out_valid, 1'b0);
    check("rel_hold_data",  bus.out_data, 64'h0);
    drive(6'b000000, 1'b0, 64'hDEAD, 1'b1, 1'b0, 1'b0);
    tick();
    check("rel_adv_data",  bus.out_data, 64'hDEAD);
    check("rel_adv_valid", bus.out_valid, 1'b1);

    // bubble keeps the looped-back tag
    drive(6'b000000, 1'b0, 64'h1111, 1'b1, 1'b0, 1'b1);
    tick();
    check("pre_bub_loop", bus.dslot_loop_o, 1'b1);
    drive(6'b000111, 1'b0, 64'h1234, 1'b1, 1'b0, 1'b0);
    tick();
    check("bub_valid",  bus.out_valid, 1'b0);
    check("bub_data",   bus.out_data, 64'h0);
    check("bub_loop",   bus.dslot_loop_o, 1'b1);
    check("bub_status", status, 2'd0);
`ifdef PIPE_REG_PERF_EN
    check("bub_cnt", bus.bubble_cnt, 4'd1);
`endif

    // hold for 5 cycles
    drive(6'b000000, 1'b0, 64'hABCD, 1'b1, 1'b0, 1'b0);
    tick();
    check("load_data", bus.out_data, 64'hABCD);
    for (int i = 0; i < 5; i++) exp_q.push_back(64'hABCD);
    drive(6'b001111, 1'b0, 64'h5555, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_data_%0d", i), bus.out_data, exp_q.pop_front());
      check($sformatf("hold_status_%0d", i), status, 2'd2);
    end
    check("hold_loop",  bus.dslot_loop_o, 1'b0);
    check("hold_dslot", bus.out_dslot, 1'b0);
`ifdef PIPE_REG_PERF_EN
    check("hold_cnt", bus.hold_cnt, 4'd5);
`endif
    drive(6'b000000, 1'b0, 64'h6666, 1'b1, 1'b0, 1'b0);
    tick();
    check("hold_rel_data", bus.out_data, 64'h6666);

    // flush beats stall
    drive(6'b000000, 1'b0, 64'h7777, 1'b1, 1'b1, 1'b1);
    tick();
    check("pre_fl_dslot", bus.out_dslot, 1'b1);
    check("pre_fl_loop",  bus.dslot_loop_o, 1'b1);
    drive(6'b001111, 1'b1, 64'h8888, 1'b1, 1'b1, 1'b1);
    tick();
    check("fl_valid",  bus.out_valid, 1'b0);
    check("fl_dslot",  bus.out_dslot, 1'b0);
    check("fl_loop",   bus.dslot_loop_o, 1'b0);
    check("fl_data",   bus.out_data, 64'h0);
    check("fl_status", status, 2'd0);
`ifdef PIPE_REG_PERF_EN
    check("fl_cnt", bus.flush_cnt, 4'd1);
`endif

    // delay-slot tags
    drive(6'b000000, 1'b0, 64'h8888, 1'b1, 1'b0, 1'b1);
    tick();
    check("ds_loop",  bus.dslot_loop_o, 1'b1);
    check("ds_dslot0", bus.out_dslot, 1'b0);
    drive(6'b000000, 1'b0, 64'h9999, 1'b1, 1'b1, 1'b0);
    tick();
    check("ds_dslot1", bus.out_dslot, 1'b1);
    check("ds_loop0",  bus.dslot_loop_o, 1'b0);
    check("ds_data",   bus.out_data, 64'h9999);
    drive(6'b000000, 1'b0, 64'hAAAA, 1'b0, 1'b1, 1'b0);
    tick();
    check("inv_dslot", bus.out_dslot, 1'b0);
    check("inv_data",  bus.out_data, 64'h0);
    check("inv_valid", bus.out_valid, 1'b0);

    // downstream-only stall advances
    drive(6'b001000, 1'b0, 64'hBBBB, 1'b1, 1'b0, 1'b0);
    tick();
    check("ill_data",  bus.out_data, 64'hBBBB);
    check("ill_valid", bus.out_valid, 1'b1);

`ifdef PIPE_REG_PERF_EN
    // saturation then clear coincident with a bubble
    drive(6'b000111, 1'b0, 64'hCCCC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("bub_sat", bus.bubble_cnt, 4'd15);
    bus.perf_clr = 1'b1;
    tick();
    bus.perf_clr = 1'b0;
    check("clr_bub",   bus.bubble_cnt, 4'd0);
    check("clr_hold",  bus.hold_cnt, 4'd0);
    check("clr_flush", bus.flush_cnt, 4'd0);
`endif

    // last stage: its own stall bit alone bubbles rather than holds
    bus_l.in_data = 64'hC0DE; bus_l.in_valid = 1'b1; bus_l.stall = 6'b000000;
    tick();
    check("last_adv_valid", bus_l.out_valid, 1'b1);
    check("last_adv_data",  bus_l.out_data, 64'hC0DE);
    bus_l.in_data = 64'hF00D; bus_l.stall = 6'b100000;
    tick();
    check("last_bub_valid", bus_l.out_valid, 1'b0);
    check("last_bub_data",  bus_l.out_data, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
